// File: rtl/step_dec_pkg.sv
// Shared constants for the step/dir decoder: FSM state encoding, default widths, direction sense.
// Latency: n/a (package only).
// Backpressure: n/a.
package step_dec_pkg;

  localparam int POS_WIDTH_DEF = 32;

  // dir level that means "+1 per step"
  localparam logic DIR_PLUS = 1'b1;

  // Pulse qualifier FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a synced rising edge
  localparam logic [1:0] ST_QUAL = 2'd1;  // step high, counting toward MIN_HIGH_CYCLES
  localparam logic [1:0] ST_HIGH = 2'd2;  // step applied (or ignored), waiting for step low

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level input.
// Latency: 2 clock cycles from d to q.
// Backpressure: none; free-running.
// Ports: clock, reset (sync active-low, clears both flops), d (async in), q (synced out).
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Decodes a step pulse train plus dir level into signed position, step rate, error flags, snapshot.
// Latency: position moves MIN_HIGH_CYCLES+2 cycles after step_in rises; flags are registered.
// Backpressure: none on inputs; snapshot is held until snap_ack.
// Ports: clock/reset (sync active-low); step_in/dir_in async; clear, preset_en/preset_val control;
//        position, step_rate, limit_hit, glitch_err, dir_err status; snap_req/snap_ack/snap_valid/snap_pos.
module step_dir_decoder
  import step_dec_pkg::*;
#(
  parameter int POS_WIDTH        = POS_WIDTH_DEF,
  parameter int MIN_HIGH_CYCLES  = 4,
  parameter int DIR_SETUP_CYCLES = 2,
  parameter int SOFT_MIN         = -100000,
  parameter int SOFT_MAX         = 100000,
  parameter int RATE_WINDOW      = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic                 clear,
  input  logic                 preset_en,
  input  logic [POS_WIDTH-1:0] preset_val,
  output logic [POS_WIDTH-1:0] position,
  output logic [31:0]          step_rate,
  output logic                 limit_hit,
  output logic                 glitch_err,
  output logic                 dir_err,
  input  logic                 snap_req,
  output logic                 snap_valid,
  output logic [POS_WIDTH-1:0] snap_pos,
  input  logic                 snap_ack
);

  localparam logic [31:0] MIN_HIGH  = 32'(MIN_HIGH_CYCLES);
  localparam logic [31:0] DIR_SETUP = 32'(DIR_SETUP_CYCLES);
  localparam logic [31:0] WIN_LAST  = 32'(RATE_WINDOW - 1);
  localparam logic signed [POS_WIDTH:0] MAX_EXT = (POS_WIDTH+1)'(SOFT_MAX);
  localparam logic signed [POS_WIDTH:0] MIN_EXT = (POS_WIDTH+1)'(SOFT_MIN);
  localparam logic signed [POS_WIDTH:0] ONE_EXT = (POS_WIDTH+1)'(1);

  logic        step_s, dir_s, dir_prev, dir_lat;
  logic [1:0]  fill;
  logic [1:0]  state;
  logic [31:0] high_cnt, dir_stable, stable_now;
  logic [31:0] win_cycle, win_steps;
  logic        dir_chg, rise, apply, step_dir, glitch_det, dir_det, step_oob;
  logic signed [POS_WIDTH:0] pos_ext, step_next, pre_ext;

  sync2 u_sync_step (.clock(clock), .reset(reset), .d(step_in), .q(step_s));
  sync2 u_sync_dir  (.clock(clock), .reset(reset), .d(dir_in),  .q(dir_s));

  // The synchronizers hold reset zeros for two cycles. fill==2 marks the first cycle whose
  // synced step is real; a step already high then is treated as mid-pulse, not as a new edge.
  assign rise       = (state == ST_IDLE) && (fill == 2'd3) && step_s;
  assign dir_chg    = (dir_s != dir_prev);
  assign stable_now = dir_chg ? 32'd0 : dir_stable;

  always_comb begin
    apply      = 1'b0;
    step_dir   = dir_lat;
    glitch_det = 1'b0;
    dir_det    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          dir_det = (stable_now < DIR_SETUP);
          if (MIN_HIGH <= 32'd1) begin
            apply    = 1'b1;
            step_dir = dir_s;
          end
        end
      end
      ST_QUAL: begin
        dir_det = dir_chg;
        if (step_s) apply = (high_cnt + 32'd1 == MIN_HIGH);
        else        glitch_det = 1'b1;
      end
      ST_HIGH: dir_det = dir_chg;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      fill       <= 2'd0;
      high_cnt   <= 32'd0;
      dir_lat    <= 1'b0;
      dir_prev   <= 1'b0;
      dir_stable <= 32'd0;
      glitch_err <= 1'b0;
      dir_err    <= 1'b0;
    end else begin
      glitch_err <= glitch_det;
      dir_err    <= dir_det;
      dir_prev   <= dir_s;
      dir_stable <= (stable_now == '1) ? stable_now : stable_now + 32'd1;
      if (fill != 2'd3) fill <= fill + 2'd1;
      case (state)
        ST_IDLE: begin
          if (fill == 2'd2) begin
            if (step_s) state <= ST_HIGH;
          end else if (rise) begin
            dir_lat  <= dir_s;
            high_cnt <= 32'd1;
            state    <= apply ? ST_HIGH : ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (!step_s) state <= ST_IDLE;
          else begin
            high_cnt <= high_cnt + 32'd1;
            if (apply) state <= ST_HIGH;
          end
        end
        ST_HIGH: if (!step_s) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Position: one extra bit of headroom so the limit compare cannot wrap.
  assign pos_ext   = $signed({position[POS_WIDTH-1], position});
  assign pre_ext   = $signed({preset_val[POS_WIDTH-1], preset_val});
  assign step_next = (step_dir == DIR_PLUS) ? pos_ext + ONE_EXT : pos_ext - ONE_EXT;
  assign step_oob  = (step_next > MAX_EXT) || (step_next < MIN_EXT);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      position  <= '0;
      limit_hit <= 1'b0;
    end else if (preset_en) begin
      if (pre_ext > MAX_EXT) begin
        position  <= MAX_EXT[POS_WIDTH-1:0];
        limit_hit <= 1'b1;
      end else if (pre_ext < MIN_EXT) begin
        position  <= MIN_EXT[POS_WIDTH-1:0];
        limit_hit <= 1'b1;
      end else begin
        position  <= preset_val;
      end
    end else if (apply) begin
      // A step pre-empted by clear/preset above is dropped on purpose.
      if (step_oob) limit_hit <= 1'b1;
      else          position  <= step_next[POS_WIDTH-1:0];
    end
  end

  // Rate window: counts every qualified step, independent of limits and clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      win_cycle <= 32'd0;
      win_steps <= 32'd0;
      step_rate <= 32'd0;
    end else if (win_cycle == WIN_LAST) begin
      win_cycle <= 32'd0;
      step_rate <= win_steps;
      win_steps <= 32'(apply);
    end else begin
      win_cycle <= win_cycle + 32'd1;
      win_steps <= win_steps + 32'(apply);
    end
  end

  // Snapshot: ack+req on the same cycle releases and recaptures in one step.
  always_ff @(posedge clock) begin
    if (!reset) begin
      snap_valid <= 1'b0;
      snap_pos   <= '0;
    end else if (!snap_valid) begin
      if (snap_req) begin
        snap_valid <= 1'b1;
        snap_pos   <= position;
      end
    end else if (snap_ack) begin
      if (snap_req) snap_pos   <= position;
      else          snap_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
module tb_step_dir_decoder;

  localparam int MINH = 4;
  localparam int SMAX = 100000;
  localparam int SMIN = -100000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        step_in = 1'b0, dir_in = 1'b0, clear = 1'b0, preset_en = 1'b0;
  logic [31:0] preset_val = '0;
  logic [31:0] position, step_rate, snap_pos;
  logic        limit_hit, glitch_err, dir_err, snap_valid;
  logic        snap_req = 1'b0, snap_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  int exp_pos = 0;
  bit exp_lim = 1'b0;
  int exp_gl = 0, exp_de = 0;
  int gl_seen = 0, de_seen = 0;
  int gl_base = 0, de_base = 0;

  step_dir_decoder #(.RATE_WINDOW(100)) dut (
    .clock(clock), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .clear(clear), .preset_en(preset_en), .preset_val(preset_val),
    .position(position), .step_rate(step_rate), .limit_hit(limit_hit),
    .glitch_err(glitch_err), .dir_err(dir_err), .snap_req(snap_req),
    .snap_valid(snap_valid), .snap_pos(snap_pos), .snap_ack(snap_ack)
  );

  always #5 clock = ~clock;

  // Count error-pulse cycles just after each active edge.
  always @(posedge clock) begin
    #1;
    if (glitch_err === 1'b1) gl_seen = gl_seen + 1;
    if (dir_err === 1'b1) de_seen = de_seen + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_step(input bit d);
    int nxt;
    nxt = exp_pos + (d ? 1 : -1);
    if (nxt > SMAX || nxt < SMIN) exp_lim = 1'b1;
    else exp_pos = nxt;
  endtask

  task automatic base_counts();
    gl_base = gl_seen; de_base = de_seen; exp_gl = 0; exp_de = 0;
  endtask

  // One pulse: low phase (optional dir toggle gap cycles before the rise), high phase
  // (optional dir flip on its second cycle), then a settle gap. Updates the model.
  task automatic pulse(input int low_len, input int gap, input int high_len, input bit mid_flip);
    bit rd;
    for (int i = 0; i < low_len; i++) begin
      step_in = 1'b0;
      if (gap != 0 && i == low_len - gap) dir_in = ~dir_in;
      tick(1);
    end
    rd = dir_in;
    for (int i = 0; i < high_len; i++) begin
      step_in = 1'b1;
      if (mid_flip && i == 1) dir_in = ~dir_in;
      tick(1);
    end
    step_in = 1'b0;
    if (high_len >= MINH) model_step(rd);
    else exp_gl++;
    if (gap == 1) exp_de++;
    if (mid_flip && high_len >= 2) exp_de++;
    tick(8);
  endtask

  task automatic do_reset();
    reset = 1'b0; step_in = 1'b0; dir_in = 1'b0; clear = 1'b0; preset_en = 1'b0;
    snap_req = 1'b0; snap_ack = 1'b0;
    tick(3);
    reset = 1'b1;
    exp_pos = 0; exp_lim = 1'b0;
  endtask

  task automatic do_preset(input int v);
    preset_en = 1'b1; preset_val = v; tick(1); preset_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_pos = 0; exp_lim = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (position !== 32'd0) begin failures++; $display("FAIL reset_pos got=%0d want=0", position); end
    checks++; if (step_rate !== 32'd0) begin failures++; $display("FAIL reset_rate got=%0d want=0", step_rate); end
    checks++; if ({limit_hit, glitch_err, dir_err, snap_valid} !== 4'b0) begin failures++;
      $display("FAIL reset_flags got=%b want=0000", {limit_hit, glitch_err, dir_err, snap_valid}); end
    checks++; if (snap_pos !== 32'd0) begin failures++; $display("FAIL reset_snap got=%0d want=0", snap_pos); end
  endtask

  task automatic test_basic();
    dir_in = 1'b1; tick(5);
    base_counts();
    for (int i = 0; i < 8; i++) pulse(10, 0, 6, 1'b0);
    checks++; if ($signed(position) !== 8) begin failures++; $display("FAIL basic_pos got=%0d want=8", $signed(position)); end
    checks++; if (gl_seen - gl_base !== 0 || de_seen - de_base !== 0) begin failures++;
      $display("FAIL basic_errs glitch=%0d dir=%0d want=0,0", gl_seen - gl_base, de_seen - de_base); end
  endtask

  task automatic test_glitch();
    base_counts();
    pulse(10, 0, 3, 1'b0);
    checks++; if ($signed(position) !== 8) begin failures++; $display("FAIL glitch_pos got=%0d want=8", $signed(position)); end
    checks++; if (gl_seen - gl_base !== 1) begin failures++; $display("FAIL glitch_pulse cycles=%0d want=1", gl_seen - gl_base); end
  endtask

  task automatic test_dir_setup();
    base_counts();
    pulse(10, 1, 6, 1'b0);
    checks++; if ($signed(position) !== 7) begin failures++; $display("FAIL dir_late_pos got=%0d want=7", $signed(position)); end
    checks++; if (de_seen - de_base !== 1) begin failures++; $display("FAIL dir_late_err cycles=%0d want=1", de_seen - de_base); end
    pulse(10, 2, 6, 1'b0);
    checks++; if ($signed(position) !== 8 || de_seen - de_base !== 1) begin failures++;
      $display("FAIL dir_ok_setup pos=%0d errs=%0d want=8,1", $signed(position), de_seen - de_base); end
    pulse(10, 0, 6, 1'b1);
    checks++; if ($signed(position) !== 9 || de_seen - de_base !== 2) begin failures++;
      $display("FAIL dir_flip_high pos=%0d errs=%0d want=9,2", $signed(position), de_seen - de_base); end
  endtask

  task automatic test_limits();
    do_clear();
    do_preset(99999); exp_pos = 99999;
    dir_in = 1'b1; tick(4);
    for (int i = 0; i < 3; i++) pulse(5, 0, 6, 1'b0);
    checks++; if ($signed(position) !== 100000 || limit_hit !== 1'b1) begin failures++;
      $display("FAIL limit_max pos=%0d lim=%b want=100000,1", $signed(position), limit_hit); end
    do_clear();
    checks++; if (position !== 32'd0 || limit_hit !== 1'b0) begin failures++;
      $display("FAIL limit_clear pos=%0d lim=%b want=0,0", $signed(position), limit_hit); end
    do_preset(200000); tick(1);
    checks++; if ($signed(position) !== 100000 || limit_hit !== 1'b1) begin failures++;
      $display("FAIL preset_sat_hi pos=%0d lim=%b want=100000,1", $signed(position), limit_hit); end
    do_clear();
    do_preset(-300000); tick(1);
    checks++; if ($signed(position) !== -100000 || limit_hit !== 1'b1) begin failures++;
      $display("FAIL preset_sat_lo pos=%0d lim=%b want=-100000,1", $signed(position), limit_hit); end
    do_clear();
    do_preset(-100000); exp_pos = -100000; tick(1);
    checks++; if ($signed(position) !== -100000 || limit_hit !== 1'b0) begin failures++;
      $display("FAIL preset_edge pos=%0d lim=%b want=-100000,0", $signed(position), limit_hit); end
    dir_in = 1'b0; tick(4);
    pulse(5, 0, 6, 1'b0);
    checks++; if ($signed(position) !== exp_pos || limit_hit !== exp_lim) begin failures++;
      $display("FAIL limit_min pos=%0d lim=%b want=%0d,%b", $signed(position), limit_hit, exp_pos, exp_lim); end
    do_clear();
  endtask

  task automatic test_priority();
    do_preset(5); exp_pos = 5;
    dir_in = 1'b1; tick(4);
    // Raw rise captured on edge r; the step applies on edge r+5, exactly when clear is sampled.
    step_in = 1'b1; tick(5);
    clear = 1'b1; tick(1); clear = 1'b0;
    tick(1); step_in = 1'b0; tick(8);
    exp_pos = 0;
    checks++; if ($signed(position) !== 0) begin failures++; $display("FAIL clear_vs_step got=%0d want=0", $signed(position)); end
    clear = 1'b1; preset_en = 1'b1; preset_val = 9; tick(1); clear = 1'b0; preset_en = 1'b0;
    checks++; if ($signed(position) !== 0) begin failures++; $display("FAIL clear_vs_preset got=%0d want=0", $signed(position)); end
  endtask

  task automatic test_snapshot();
    do_preset(5); exp_pos = 5;
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    checks++; if (snap_valid !== 1'b1 || $signed(snap_pos) !== 5) begin failures++;
      $display("FAIL snap_take valid=%b pos=%0d want=1,5", snap_valid, $signed(snap_pos)); end
    dir_in = 1'b1; tick(4);
    pulse(5, 0, 6, 1'b0); pulse(5, 0, 6, 1'b0);
    checks++; if ($signed(position) !== 7 || $signed(snap_pos) !== 5 || snap_valid !== 1'b1) begin failures++;
      $display("FAIL snap_hold pos=%0d snap=%0d valid=%b want=7,5,1", $signed(position), $signed(snap_pos), snap_valid); end
    snap_req = 1'b1; tick(1); snap_req = 1'b0;
    checks++; if ($signed(snap_pos) !== 5) begin failures++; $display("FAIL snap_req_ignored got=%0d want=5", $signed(snap_pos)); end
    snap_req = 1'b1; snap_ack = 1'b1; tick(1); snap_req = 1'b0; snap_ack = 1'b0;
    checks++; if (snap_valid !== 1'b1 || $signed(snap_pos) !== 7) begin failures++;
      $display("FAIL snap_refresh valid=%b pos=%0d want=1,7", snap_valid, $signed(snap_pos)); end
    do_clear();
    checks++; if ($signed(snap_pos) !== 7 || position !== 32'd0) begin failures++;
      $display("FAIL snap_vs_clear snap=%0d pos=%0d want=7,0", $signed(snap_pos), $signed(position)); end
    snap_ack = 1'b1; tick(1); snap_ack = 1'b0;
    checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL snap_release valid=%b want=0", snap_valid); end
  endtask

  task automatic test_random();
    int lo, gp, hi;
    bit mf;
    base_counts();
    for (int n = 0; n < 30; n++) begin
      lo = $urandom_range(10, 3);
      gp = ($urandom_range(1, 0) == 1) ? $urandom_range(lo, 1) : 0;
      hi = $urandom_range(8, 1);
      mf = ($urandom_range(3, 0) == 0) && (hi >= 2);
      pulse(lo, gp, hi, mf);
      checks++; if ($signed(position) !== exp_pos) begin failures++;
        $display("FAIL rand_pos[%0d] got=%0d want=%0d (lo=%0d gap=%0d hi=%0d flip=%b)", n, $signed(position), exp_pos, lo, gp, hi, mf); end
    end
    checks++; if (gl_seen - gl_base !== exp_gl) begin failures++;
      $display("FAIL rand_glitch got=%0d want=%0d", gl_seen - gl_base, exp_gl); end
    checks++; if (de_seen - de_base !== exp_de) begin failures++;
      $display("FAIL rand_dir_err got=%0d want=%0d", de_seen - de_base, exp_de); end
    checks++; if (limit_hit !== exp_lim) begin failures++; $display("FAIL rand_limit got=%b want=%b", limit_hit, exp_lim); end
  endtask

  task automatic test_rate();
    do_reset();
    dir_in = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      step_in = 1'b1; tick(5); step_in = 1'b0; tick(3);
    end
    tick(17);  // 99 edges since reset release
    checks++; if (step_rate !== 32'd0) begin failures++; $display("FAIL rate_before_wrap got=%0d want=0", step_rate); end
    tick(1);
    checks++; if (step_rate !== 32'd10) begin failures++; $display("FAIL rate_wrap got=%0d want=10", step_rate); end
    for (int i = 0; i < 2; i++) begin
      step_in = 1'b1; tick(5); step_in = 1'b0; tick(3);
    end
    tick(84);  // 200 edges
    checks++; if (step_rate !== 32'd2) begin failures++; $display("FAIL rate_window2 got=%0d want=2", step_rate); end
    checks++; if ($signed(position) !== 12) begin failures++; $display("FAIL rate_pos got=%0d want=12", $signed(position)); end
  endtask

  task automatic test_reset_mid_pulse();
    do_preset(3);
    dir_in = 1'b1; tick(4);
    step_in = 1'b1; tick(8);
    checks++; if ($signed(position) !== 4) begin failures++; $display("FAIL pre_reset_pos got=%0d want=4", $signed(position)); end
    reset = 1'b0; tick(2);
    checks++; if (position !== 32'd0 || step_rate !== 32'd0 || limit_hit !== 1'b0 || snap_valid !== 1'b0) begin failures++;
      $display("FAIL mid_reset_outs pos=%0d rate=%0d lim=%b snap=%b want=0", $signed(position), step_rate, limit_hit, snap_valid); end
    reset = 1'b1;
    base_counts();
    tick(12);
    checks++; if (position !== 32'd0 || gl_seen - gl_base !== 0) begin failures++;
      $display("FAIL held_high_after_reset pos=%0d glitch=%0d want=0,0", $signed(position), gl_seen - gl_base); end
    step_in = 1'b0; tick(3);
    step_in = 1'b1; tick(6); step_in = 1'b0; tick(8);
    checks++; if ($signed(position) !== 1) begin failures++; $display("FAIL fresh_edge_after_reset got=%0d want=1", $signed(position)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_dir_setup();
    test_limits();
    test_priority();
    test_snapshot();
    test_random();
    test_rate();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
